tri_feeder: RTL and testbench

- Front end of the raster pipeline; the sending side of the rasterizer's triangle handshake.
- On each new frame, streams a fixed triangle list from an on-chip vertex ROM.
- Issues one triangle at a time on vert1/vert2/vert3 with a valid/ready handshake.
- Marks the last triangle of the object with obj_done, which triggers the rasterizer's buffer swap.

---
 rtl/raster_pkg.sv | 32 +++
 rtl/xilinx_single_port_ram_read_first.sv | 40 ++++
 rtl/tri_feeder.sv | 145 ++++++++++++++
 tb/tb_tri_feeder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared raster-pipeline types: vertex coordinate layout, ROM word packing
// and the feeder state encoding.
package raster_pkg;

  localparam int COORD_W = 9;
  localparam int VX      = 2;
  localparam int VY      = 1;
  localparam int VZ      = 0;

  localparam int WORD_W  = 3 * COORD_W;
  localparam int X_LSB   = 2 * COORD_W;
  localparam int Y_LSB   = COORD_W;
  localparam int Z_LSB   = 0;

  typedef logic [COORD_W-1:0] coord_t;
  typedef coord_t [2:0] vertex_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT
  } feeder_state_t;

  function automatic vertex_t unpack_vertex(input logic [WORD_W-1:0] w);
    vertex_t v;
    v[VX] = w[X_LSB +: COORD_W];
    v[VY] = w[Y_LSB +: COORD_W];
    v[VZ] = w[Z_LSB +: COORD_W];
    return v;
  endfunction

endpackage

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM with an output register: two-cycle
// read latency from address to douta when regcea is held high.
module xilinx_single_port_ram_read_first #(
  parameter int    RAM_WIDTH = 27,
  parameter int    RAM_DEPTH = 36,
  parameter string INIT_FILE = ""
) (
  input  logic                         clka,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         wea,
  input  logic                         ena,
  input  logic                         rsta,
  input  logic                         regcea,
  output logic [RAM_WIDTH-1:0]         douta
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_q;
  logic [RAM_WIDTH-1:0] douta_q;

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      ram_data_q <= mem[addra];
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) douta_q <= '0;
    else if (regcea) douta_q <= ram_data_q;
  end

  assign douta = douta_q;

  // The image is attached by the implementation flow; no name means the array is loaded externally.
  if (INIT_FILE == "") begin : g_no_image
  end

endmodule

// File: rtl/tri_feeder.sv
// Streams a fixed triangle mesh from the vertex ROM to the rasterizer, one
// triangle per valid/ready transfer, flagging the last one with obj_done.
module tri_feeder
  import raster_pkg::*;
#(
  parameter int    NUM_TRIS  = 12,
  parameter int    ROM_DEPTH = 3 * NUM_TRIS,
  parameter string INIT_FILE = "mesh_init.mem"
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  logic    new_frame,
  input  logic    ready_in,
  output vertex_t vert1,
  output vertex_t vert2,
  output vertex_t vert3,
  output logic    valid_out,
  output logic    obj_done,
  output logic    busy,
  output logic    frame_sent
);

  localparam int ADDR_W = $clog2(ROM_DEPTH);
  localparam int IDX_W  = $clog2(NUM_TRIS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRIS - 1);

  feeder_state_t     state_q, state_d;
  logic [IDX_W-1:0]  tri_idx_q, tri_idx_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              pending_q, pending_d;
  vertex_t           vert1_q, vert1_d, vert2_q, vert2_d, vert3_q, vert3_d;
  logic              valid_q, valid_d, obj_done_q, obj_done_d;
  logic              busy_q, busy_d, frame_sent_q, frame_sent_d;
  logic [ADDR_W-1:0] base_addr, rom_addr;
  logic [WORD_W-1:0] rom_dout;

  always_comb begin
    base_addr = (ADDR_W'(tri_idx_q) << 1) + ADDR_W'(tri_idx_q);
    rom_addr  = base_addr;
    if (state_q == ST_FETCH && cnt_q < 3'd3) rom_addr = base_addr + ADDR_W'(cnt_q[1:0]);
  end

  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH (WORD_W),
    .RAM_DEPTH (ROM_DEPTH),
    .INIT_FILE (INIT_FILE)
  ) mesh_rom (
    .clka   (clk_in),
    .addra  (rom_addr),
    .dina   ('0),
    .wea    (1'b0),
    .ena    (1'b1),
    .rsta   (rst_in),
    .regcea (1'b1),
    .douta  (rom_dout)
  );

  always_comb begin
    state_d      = state_q;
    tri_idx_d    = tri_idx_q;
    cnt_d        = cnt_q;
    vert1_d      = vert1_q;
    vert2_d      = vert2_q;
    vert3_d      = vert3_q;
    frame_sent_d = 1'b0;
    pending_d    = pending_q | (new_frame && state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (new_frame || pending_q) begin
          pending_d = 1'b0;
          tri_idx_d = '0;
          cnt_d     = '0;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Addresses go out at cnt 0..2; each word lands two cycles later.
        cnt_d = cnt_q + 3'd1;
        case (cnt_q)
          3'd2: vert1_d = unpack_vertex(rom_dout);
          3'd3: vert2_d = unpack_vertex(rom_dout);
          3'd4: begin
            vert3_d = unpack_vertex(rom_dout);
            cnt_d   = '0;
            state_d = ST_PRESENT;
          end
          default: ;
        endcase
      end
      ST_PRESENT: begin
        if (ready_in) begin
          if (tri_idx_q == LAST_IDX) begin
            frame_sent_d = 1'b1;
            tri_idx_d    = '0;
            state_d      = ST_IDLE;
          end else begin
            tri_idx_d = tri_idx_q + 1'b1;
            state_d   = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d    = (state_d == ST_PRESENT);
    obj_done_d = valid_d && (tri_idx_d == LAST_IDX);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      tri_idx_q    <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      vert1_q      <= '0;
      vert2_q      <= '0;
      vert3_q      <= '0;
      valid_q      <= 1'b0;
      obj_done_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_sent_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tri_idx_q    <= tri_idx_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      vert1_q      <= vert1_d;
      vert2_q      <= vert2_d;
      vert3_q      <= vert3_d;
      valid_q      <= valid_d;
      obj_done_q   <= obj_done_d;
      busy_q       <= busy_d;
      frame_sent_q <= frame_sent_d;
    end
  end

  assign vert1      = vert1_q;
  assign vert2      = vert2_q;
  assign vert3      = vert3_q;
  assign valid_out  = valid_q;
  assign obj_done   = obj_done_q;
  assign busy       = busy_q;
  assign frame_sent = frame_sent_q;

endmodule

// File: tb/tb_tri_feeder.sv
// Directed bench for tri_feeder: a 2-triangle and a 1-triangle instance,
// with a scoreboard of expected triangles checked as the feeder presents them.
module tb_tri_feeder;
  import raster_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic    rst, nf2, rdy2, nf1, rdy1;
  vertex_t v1_2, v2_2, v3_2, v1_1, v2_1, v3_1;
  logic    val2, od2, busy2, fs2, val1, od1, busy1, fs1;

  tri_feeder #(.NUM_TRIS(2)) u_dut2 (
    .clk_in(clk), .rst_in(rst), .new_frame(nf2), .ready_in(rdy2),
    .vert1(v1_2), .vert2(v2_2), .vert3(v3_2),
    .valid_out(val2), .obj_done(od2), .busy(busy2), .frame_sent(fs2)
  );

  tri_feeder #(.NUM_TRIS(1)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .new_frame(nf1), .ready_in(rdy1),
    .vert1(v1_1), .vert2(v2_1), .vert3(v3_1),
    .valid_out(val1), .obj_done(od1), .busy(busy1), .frame_sent(fs1)
  );

  typedef struct packed {
    logic [26:0] v1;
    logic [26:0] v2;
    logic [26:0] v3;
    logic        od;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0, miscompares = 0;
  int   cyc = 0;
  int   xfers = 0, objs = 0, frames = 0;
  logic last_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [26:0] word(input int i);
    return {9'(3 * i + 1), 9'(3 * i + 2), 9'(3 * i + 3)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame2();
    sb.push_back({word(0), word(1), word(2), 1'b0});
    sb.push_back({word(3), word(4), word(5), 1'b1});
  endtask

  task automatic wait_valid(output int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!val2 && n < 50);
    check("wait_valid_timeout", 64'(val2), 64'(1));
    c = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy2 && n < 100);
    check("wait_idle_timeout", 64'(busy2), 64'(0));
    repeat (2) tick();
  endtask

  // Scoreboard monitor for the 2-triangle instance.
  always @(negedge clk) begin
    if (fs2 || last_prev) check("frame_sent_timing", 64'(fs2), 64'(last_prev));
    if (fs2) frames++;
    last_prev = val2 && rdy2 && od2;
    if (val2) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(val2), 64'(0));
      end else begin
        mon_e = sb[0];
        check("vert1", 64'(v1_2), 64'(mon_e.v1));
        check("vert2", 64'(v2_2), 64'(mon_e.v2));
        check("vert3", 64'(v3_2), 64'(mon_e.v3));
        check("obj_done", 64'(od2), 64'(mon_e.od));
        if (rdy2) begin
          void'(sb.pop_front());
          xfers++;
          if (od2) objs++;
        end
      end
    end
  end

  initial begin
    int k, c, c2, x0, o0, f0, n;
    rst = 1'b1; nf2 = 1'b0; nf1 = 1'b0; rdy2 = 1'b1; rdy1 = 1'b1;
    for (int i = 0; i < 6; i++) u_dut2.mesh_rom.mem[i] <= word(i);
    for (int i = 0; i < 3; i++) u_dut1.mesh_rom.mem[i] <= word(i + 10);
    repeat (3) tick();

    check("rst_valid", 64'(val2), 64'(0));
    check("rst_obj_done", 64'(od2), 64'(0));
    check("rst_busy", 64'(busy2), 64'(0));
    check("rst_frame_sent", 64'(fs2), 64'(0));
    check("rst_vert1", 64'(v1_2), 64'(0));
    check("rst_vert2", 64'(v2_2), 64'(0));
    check("rst_vert3", 64'(v3_2), 64'(0));
    check("rst_valid_n1", 64'(val1), 64'(0));
    rst = 1'b0;
    tick();
    check("valid_after_reset", 64'(val2), 64'(0));

    // Basic frame with latency measurement
    x0 = xfers; o0 = objs; f0 = frames;
    push_frame2();
    nf2 = 1'b1; k = cyc; tick(); nf2 = 1'b0;
    wait_valid(c);
    check("latency_first", 64'(c - k), 64'(6));
    wait_valid(c2);
    check("latency_next", 64'(c2 - c), 64'(6));
    wait_idle();
    check("basic_xfers", 64'(xfers - x0), 64'(2));
    check("basic_objs", 64'(objs - o0), 64'(1));
    check("basic_frames", 64'(frames - f0), 64'(1));

    // Backpressure: 20 cycles of ready low while presenting
    x0 = xfers; f0 = frames;
    rdy2 = 1'b0;
    push_frame2();
    nf2 = 1'b1; tick(); nf2 = 1'b0;
    wait_valid(c);
    repeat (20) begin
      tick();
      check("bp_hold_valid", 64'(val2), 64'(1));
    end
    check("bp_no_xfer", 64'(xfers - x0), 64'(0));
    rdy2 = 1'b1;
    tick();
    check("bp_one_xfer", 64'(xfers - x0), 64'(1));
    check("bp_valid_drop", 64'(val2), 64'(0));
    wait_idle();
    check("bp_xfers", 64'(xfers - x0), 64'(2));
    check("bp_frames", 64'(frames - f0), 64'(1));

    // Pending: two extra pulses during triangle 0 collapse into one frame
    x0 = xfers; o0 = objs; f0 = frames;
    push_frame2();
    nf2 = 1'b1; tick(); nf2 = 1'b0; tick();
    nf2 = 1'b1; tick(); nf2 = 1'b0; tick();
    nf2 = 1'b1; tick(); nf2 = 1'b0;
    push_frame2();
    repeat (60) tick();
    check("pend_xfers", 64'(xfers - x0), 64'(4));
    check("pend_objs", 64'(objs - o0), 64'(2));
    check("pend_frames", 64'(frames - f0), 64'(2));
    check("pend_sb_empty", 64'(sb.size()), 64'(0));
    check("pend_idle", 64'(busy2), 64'(0));

    // Reset during FETCH of triangle 1
    x0 = xfers;
    push_frame2();
    nf2 = 1'b1; tick(); nf2 = 1'b0;
    wait_valid(c);
    tick(); tick();
    check("pre_reset_busy", 64'(busy2), 64'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    sb.delete();
    check("mid_rst_valid", 64'(val2), 64'(0));
    check("mid_rst_obj_done", 64'(od2), 64'(0));
    check("mid_rst_busy", 64'(busy2), 64'(0));
    check("mid_rst_frame_sent", 64'(fs2), 64'(0));
    check("mid_rst_vert1", 64'(v1_2), 64'(0));
    check("mid_rst_vert2", 64'(v2_2), 64'(0));
    check("mid_rst_vert3", 64'(v3_2), 64'(0));
    repeat (10) tick();
    check("post_rst_idle", 64'(busy2), 64'(0));
    check("post_rst_xfers", 64'(xfers - x0), 64'(1));
    push_frame2();
    nf2 = 1'b1; tick(); nf2 = 1'b0;
    wait_idle();
    check("restart_xfers", 64'(xfers - x0), 64'(3));
    check("restart_sb_empty", 64'(sb.size()), 64'(0));

    // Single-triangle mesh
    nf1 = 1'b1; k = cyc; tick(); nf1 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!val1 && n < 30);
    check("n1_valid_timeout", 64'(val1), 64'(1));
    check("n1_latency", 64'(cyc - k), 64'(6));
    check("n1_vert1", 64'(v1_1), 64'(word(10)));
    check("n1_vert2", 64'(v2_1), 64'(word(11)));
    check("n1_vert3", 64'(v3_1), 64'(word(12)));
    check("n1_obj_done", 64'(od1), 64'(1));
    check("n1_fs_early", 64'(fs1), 64'(0));
    @(negedge clk);
    check("n1_frame_sent", 64'(fs1), 64'(1));
    check("n1_valid_drop", 64'(val1), 64'(0));
    @(negedge clk);
    check("n1_fs_pulse", 64'(fs1), 64'(0));
    check("n1_idle", 64'(busy1), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
